// File: rtl/chip4_seq_pkg.sv
// Shared types and constants for the valve sequencer: opcodes, FSM states,
// default timing and the valve pattern each op drives while running.
package chip4_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_LOAD    = 3'd1,
        OP_PUMP    = 3'd2,
        OP_WASH    = 3'd3,
        OP_COLLECT = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_CLOSE = 2'd3
    } state_t;

    localparam int DEF_STEP_CYCLES   = 1000;
    localparam int DEF_SETTLE_CYCLES = 200;

    typedef struct packed {
        logic [4:0] inlet;
        logic       prep;
        logic       stage_in;
        logic       stage_out;
        logic       sieve;
        logic       collect;
    } valve_t;

    localparam valve_t VALVES_OFF     = '0;
    // LOAD's inlet bit is filled in from the latched index at run time.
    localparam valve_t VALVES_LOAD    = '{inlet: 5'b0, prep: 1'b1, stage_in: 1'b0,
                                          stage_out: 1'b0, sieve: 1'b0, collect: 1'b0};
    localparam valve_t VALVES_PUMP    = '{inlet: 5'b0, prep: 1'b0, stage_in: 1'b1,
                                          stage_out: 1'b0, sieve: 1'b0, collect: 1'b0};
    localparam valve_t VALVES_WASH    = '{inlet: 5'b0, prep: 1'b0, stage_in: 1'b1,
                                          stage_out: 1'b1, sieve: 1'b1, collect: 1'b0};
    localparam valve_t VALVES_COLLECT = '{inlet: 5'b0, prep: 1'b0, stage_in: 1'b0,
                                          stage_out: 1'b1, sieve: 1'b0, collect: 1'b1};

    function automatic logic [4:0] inlet_onehot(input logic [2:0] idx);
        logic [4:0] oh;
        oh = 5'b00000;
        case (idx)
            3'd1: oh = 5'b00001;
            3'd2: oh = 5'b00010;
            3'd3: oh = 5'b00100;
            3'd4: oh = 5'b01000;
            3'd5: oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/seq_step_timer.sv
// Loadable step/cycle down-counter: counts STEP_CYCLES cycles per step while
// enabled, pulsing step_tick on each step's last cycle and expired on the final one.
module seq_step_timer #(
    parameter int STEP_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_steps,
    input  logic        en,
    output logic        step_tick,
    output logic        expired
);

    localparam int CW = $clog2(STEP_CYCLES + 1);
    localparam logic [CW-1:0] CYC_RELOAD = CW'(STEP_CYCLES);
    localparam logic [CW-1:0] CYC_ONE    = CW'(1);

    logic [15:0]   step_cnt;
    logic [CW-1:0] cyc_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_cnt <= '0;
            cyc_cnt  <= '0;
        end else if (load) begin
            step_cnt <= load_steps;
            cyc_cnt  <= CYC_RELOAD;
        end else if (en) begin
            // Both counters saturate at zero so a stray enable never wraps.
            if (cyc_cnt <= CYC_ONE) begin
                cyc_cnt <= CYC_RELOAD;
                if (step_cnt != 16'd0)
                    step_cnt <= step_cnt - 16'd1;
            end else begin
                cyc_cnt <= cyc_cnt - CYC_ONE;
            end
        end
    end

    assign step_tick = en && (cyc_cnt == CYC_ONE);
    assign expired   = step_tick && (step_cnt == 16'd1);

endmodule

// File: rtl/chip4_valve_sequencer.sv
// Valve sequencer: accepts one timed command at a time and walks it through
// an all-closed settle, the op's valve pattern, and a second all-closed settle.
module chip4_valve_sequencer
    import chip4_seq_pkg::*;
#(
    parameter int STEP_CYCLES   = DEF_STEP_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_arg,
    input  logic        abort,
    output logic [4:0]  inlet_ctrl,
    output logic        prep_inlet_ctrl,
    output logic        stage_inlet_ctrl,
    output logic        stage_outlet_ctrl,
    output logic        sieve_ctrl,
    output logic        collect_ctrl,
    output logic [2:0]  pump,
    output logic        busy,
    output logic        done,
    output logic        err,
    output state_t      dbg_state
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_RELOAD = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_ONE    = SW'(1);

    state_t        state_q, state_d;
    logic          accept, cmd_legal;
    logic [15:0]   cmd_steps;
    logic [2:0]    op_q, idx_q, pump_ph;
    logic [SW-1:0] settle_cnt;
    logic          settle_last, step_tick, expired;
    logic          aborted_q, done_q, err_q;
    valve_t        valves;
    logic [2:0]    pump_out;

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; ready is only offered in IDLE without abort.
    assign cmd_ready = (state_q == ST_IDLE) && !abort;
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_steps = (cmd_op == OP_LOAD) ? {3'b000, cmd_arg[15:3]} : cmd_arg;

    always_comb begin
        cmd_legal = 1'b1;
        if (cmd_op > 3'd4)
            cmd_legal = 1'b0;
        if (cmd_op == OP_LOAD && (cmd_arg[2:0] == 3'd0 || cmd_arg[2:0] > 3'd5))
            cmd_legal = 1'b0;
        if (cmd_op != OP_NOP && cmd_steps == 16'd0)
            cmd_legal = 1'b0;
    end

    seq_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_steps (cmd_steps),
        .en         (state_q == ST_RUN),
        .step_tick  (step_tick),
        .expired    (expired)
    );

    assign settle_last = (settle_cnt == SETTLE_ONE);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && cmd_legal && cmd_op != OP_NOP) state_d = ST_SETUP;
            ST_SETUP: if (abort) state_d = ST_CLOSE;
                      else if (settle_last) state_d = ST_RUN;
            ST_RUN:   if (abort || expired) state_d = ST_CLOSE;
            ST_CLOSE: if (settle_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= 3'd0;
            idx_q      <= 3'd0;
            pump_ph    <= 3'd0;
            settle_cnt <= '0;
            aborted_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept) begin
                op_q      <= cmd_op;
                idx_q     <= cmd_arg[2:0];
                aborted_q <= 1'b0;
                if (!cmd_legal)
                    err_q <= 1'b1;
                else if (cmd_op == OP_NOP)
                    done_q <= 1'b1;
            end
            if ((state_q == ST_SETUP || state_q == ST_RUN) && abort)
                aborted_q <= 1'b1;
            if (state_q == ST_CLOSE && settle_last) begin
                done_q <= !aborted_q;
                err_q  <= aborted_q;
            end
            // Each entry into SETUP or CLOSE gets a full settle interval.
            if (state_d != state_q && (state_d == ST_SETUP || state_d == ST_CLOSE))
                settle_cnt <= SETTLE_RELOAD;
            else if (settle_cnt != '0)
                settle_cnt <= settle_cnt - SETTLE_ONE;
            if (state_q == ST_SETUP && state_d == ST_RUN)
                pump_ph <= 3'b001;
            else if (step_tick)
                pump_ph <= {pump_ph[1:0], pump_ph[2]};
        end
    end

    always_comb begin
        valves   = VALVES_OFF;
        pump_out = 3'b000;
        if (state_q == ST_RUN) begin
            case (op_q)
                OP_LOAD: begin
                    valves       = VALVES_LOAD;
                    valves.inlet = inlet_onehot(idx_q);
                end
                OP_PUMP: begin
                    valves   = VALVES_PUMP;
                    pump_out = pump_ph;
                end
                OP_WASH:    valves = VALVES_WASH;
                OP_COLLECT: valves = VALVES_COLLECT;
                default:    valves = VALVES_OFF;
            endcase
        end
    end

    assign inlet_ctrl        = valves.inlet;
    assign prep_inlet_ctrl   = valves.prep;
    assign stage_inlet_ctrl  = valves.stage_in;
    assign stage_outlet_ctrl = valves.stage_out;
    assign sieve_ctrl        = valves.sieve;
    assign collect_ctrl      = valves.collect;
    assign pump              = pump_out;
    assign busy              = (state_q != ST_IDLE);
    assign done              = done_q;
    assign err               = err_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_chip4_valve_sequencer.sv
// Bench for chip4_valve_sequencer with STEP_CYCLES=4, SETTLE_CYCLES=2:
// per-cycle expected output words are queued at acceptance and compared each cycle.
module tb_chip4_valve_sequencer;
    import chip4_seq_pkg::*;

    localparam int W    = 17;
    localparam int STEP = 4;
    localparam int SETL = 2;

    logic        clk, rst_n, cmd_valid, cmd_ready, abort;
    logic [2:0]  cmd_op, pump;
    logic [15:0] cmd_arg;
    logic [4:0]  inlet_ctrl;
    logic        prep_inlet_ctrl, stage_inlet_ctrl, stage_outlet_ctrl, sieve_ctrl, collect_ctrl;
    logic        busy, done, err;
    state_t      dbg_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] word;
    int total = 0;
    int bad   = 0;

    chip4_valve_sequencer #(.STEP_CYCLES(STEP), .SETTLE_CYCLES(SETL)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_arg           (cmd_arg),
        .abort             (abort),
        .inlet_ctrl        (inlet_ctrl),
        .prep_inlet_ctrl   (prep_inlet_ctrl),
        .stage_inlet_ctrl  (stage_inlet_ctrl),
        .stage_outlet_ctrl (stage_outlet_ctrl),
        .sieve_ctrl        (sieve_ctrl),
        .collect_ctrl      (collect_ctrl),
        .pump              (pump),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .dbg_state         (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign word = {busy, done, err, cmd_ready, pump, inlet_ctrl, prep_inlet_ctrl,
                   stage_inlet_ctrl, stage_outlet_ctrl, sieve_ctrl, collect_ctrl};

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic b, input logic d, input logic e, input logic r,
                                        input logic [2:0] p, input logic [4:0] in, input logic pr,
                                        input logic si, input logic so, input logic sv, input logic co);
        return {b, d, e, r, p, in, pr, si, so, sv, co};
    endfunction

    // scoreboard: one queued word per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check_eq("out", word, e);
        end
    end

    task automatic push_cmd(input logic [2:0] op, input logic [15:0] arg, input int abort_run);
        logic [2:0]  idx;
        logic [15:0] steps;
        logic [4:0]  oh;
        logic        legal;
        int          run_len;
        idx   = arg[2:0];
        steps = (op == 3'd1) ? {3'b000, arg[15:3]} : arg;
        legal = (op <= 3'd4) && !(op == 3'd1 && (idx == 3'd0 || idx > 3'd5))
                && !(op != 3'd0 && steps == 16'd0);
        if (!legal) begin
            exp_q.push_back(mk(0,1'b0,1'b1,1'b1,3'b000,5'b0,0,0,0,0,0));
        end else if (op == 3'd0) begin
            exp_q.push_back(mk(0,1'b1,1'b0,1'b1,3'b000,5'b0,0,0,0,0,0));
        end else begin
            oh = (op == 3'd1) ? (5'b00001 << (idx - 3'd1)) : 5'b00000;
            run_len = (abort_run > 0) ? abort_run : int'(steps) * STEP;
            for (int i = 0; i < SETL; i++) exp_q.push_back(mk(1,0,0,0,3'b000,5'b0,0,0,0,0,0));
            for (int i = 0; i < run_len; i++) begin
                case (op)
                    3'd1: exp_q.push_back(mk(1,0,0,0,3'b000,oh,1,0,0,0,0));
                    3'd2: exp_q.push_back(mk(1,0,0,0,3'b001 << ((i / STEP) % 3),5'b0,0,1,0,0,0));
                    3'd3: exp_q.push_back(mk(1,0,0,0,3'b000,5'b0,0,1,1,1,0));
                    default: exp_q.push_back(mk(1,0,0,0,3'b000,5'b0,0,0,1,0,1));
                endcase
            end
            for (int i = 0; i < SETL; i++) exp_q.push_back(mk(1,0,0,0,3'b000,5'b0,0,0,0,0,0));
            if (abort_run > 0) exp_q.push_back(mk(0,1'b0,1'b1,1'b1,3'b000,5'b0,0,0,0,0,0));
            else               exp_q.push_back(mk(0,1'b1,1'b0,1'b1,3'b000,5'b0,0,0,0,0,0));
        end
    endtask

    // driver: called just after a rising edge while the DUT is idle
    task automatic send_cmd(input logic [2:0] op, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        push_cmd(op, arg, 0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain_timeout", W'(exp_q.size()), '0);
        exp_q.delete();
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 16'd0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_outputs", word, mk(0,0,0,1,3'b000,5'b0,0,0,0,0,0));
        check_eq("reset_state", W'(dbg_state), W'(ST_IDLE));
        @(posedge clk); #1;

        send_cmd(3'd1, {13'd2, 3'd3});
        wait_drain();
        send_cmd(3'd2, 16'd4);
        wait_drain();

        send_cmd(3'd6, 16'd1);          wait_drain();
        send_cmd(3'd1, {13'd1, 3'd0});  wait_drain();
        send_cmd(3'd1, {13'd1, 3'd6});  wait_drain();
        send_cmd(3'd3, 16'd0);          wait_drain();
        send_cmd(3'd0, 16'd0);          wait_drain();

        // abort on the third RUN cycle of a 5-step WASH
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_arg = 16'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        push_cmd(3'd3, 16'd5, 3);
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_drain();

        // abort while idle only blocks acceptance
        abort = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd0; cmd_arg = 16'd0;
        @(negedge clk);
        check_eq("idle_abort_blocks", word, mk(0,0,0,0,3'b000,5'b0,0,0,0,0,0));
        @(posedge clk);
        @(negedge clk);
        check_eq("idle_abort_nodone", word, mk(0,0,0,0,3'b000,5'b0,0,0,0,0,0));
        abort = 1'b0; cmd_valid = 1'b0;
        @(posedge clk); #1;

        // reset pulse in the middle of a PUMP run
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_arg = 16'd4;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("mid_pump", word, mk(1,0,0,0,3'b010,5'b0,0,1,0,0,0));
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_closed", word, mk(0,0,0,1,3'b000,5'b0,0,0,0,0,0));
        @(negedge clk);
        check_eq("rst_mid_nopulse", word, mk(0,0,0,1,3'b000,5'b0,0,0,0,0,0));
        @(posedge clk); #1;
        send_cmd(3'd0, 16'd0);
        wait_drain();

        // back-to-back COLLECTs with cmd_valid held high
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_arg = 16'd1;
        @(posedge clk); #1;
        push_cmd(3'd4, 16'd1, 0);
        push_cmd(3'd4, 16'd1, 0);
        repeat (9) @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_drain();

        // random commands, legal and illegal
        for (int k = 0; k < 8; k++) begin
            logic [2:0]  rop;
            logic [15:0] rarg;
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'd1) rarg = {13'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            else             rarg = 16'($urandom_range(0, 3));
            send_cmd(rop, rarg);
            wait_drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
